// File: rtl/input_stream.sv
// AXI4-Stream slave feeding a 65-bit stream FIFO ({tlast, data}) through a registered
// 2-entry skid buffer, with max-packet-length enforcement and packet statistics.
module input_stream #(
  parameter int AXIS_TDATA_WIDTH = 64,
  parameter int MAX_BEATS        = 1024,
  parameter int CNT_WIDTH        = 32
) (
  input  logic                        aclk,
  input  logic                        resetn,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic                        s_axis_tlast,
  output logic [64:0]                 fifo_din,
  output logic                        fifo_wr_en,
  input  logic                        fifo_full,
  output logic [CNT_WIDTH-1:0]        pkt_count,
  output logic [CNT_WIDTH-1:0]        trunc_count,
  output logic [15:0]                 beat_idx
);

  localparam logic [15:0] LAST_IDX = 16'(MAX_BEATS - 1);

  function automatic logic [63:0] zext_data(input logic [AXIS_TDATA_WIDTH-1:0] d);
    logic [63:0] r;
    r = '0;
    r[AXIS_TDATA_WIDTH-1:0] = d;
    return r;
  endfunction

  function automatic logic force_last(input logic tlast, input logic [15:0] idx);
    return tlast || (idx == LAST_IDX);
  endfunction

  logic [1:0]  occ;
  logic        ready_en;
  logic [64:0] buf_p0;
  logic [64:0] buf_p1;
  logic [64:0] buf_p0_nxt;
  logic [64:0] buf_p1_nxt;
  logic [1:0]  wr_slot;
  logic        accept;
  logic        pop;
  logic        eff_last;
  logic [64:0] new_entry;

  // Ready depends on registers only, so upstream never sees a path from fifo_full.
  assign s_axis_tready = ready_en && (occ != 2'd2);
  assign fifo_wr_en    = (occ != 2'd0) && !fifo_full;
  assign fifo_din      = (occ != 2'd0) ? buf_p0 : '0;

  assign accept    = s_axis_tvalid && s_axis_tready;
  assign pop       = fifo_wr_en;
  assign eff_last  = force_last(s_axis_tlast, beat_idx);
  assign new_entry = {eff_last, zext_data(s_axis_tdata)};
  assign wr_slot   = occ - {1'b0, pop};

  // Pop shifts the tail to the head first; the new beat lands in the first free slot.
  always_comb begin
    buf_p0_nxt = buf_p0;
    buf_p1_nxt = buf_p1;
    if (pop) begin
      buf_p0_nxt = buf_p1;
    end
    if (accept) begin
      if (wr_slot == 2'd0) begin
        buf_p0_nxt = new_entry;
      end else begin
        buf_p1_nxt = new_entry;
      end
    end
  end

  // Skid buffer storage: contents are qualified by occ, so no reset is needed.
  always_ff @(posedge aclk) begin
    buf_p0 <= buf_p0_nxt;
    buf_p1 <= buf_p1_nxt;
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      occ         <= 2'd0;
      ready_en    <= 1'b0;
      beat_idx    <= '0;
      pkt_count   <= '0;
      trunc_count <= '0;
    end else begin
      ready_en <= 1'b1;
      occ      <= occ + {1'b0, accept} - {1'b0, pop};
      if (accept) begin
        beat_idx <= eff_last ? 16'd0 : beat_idx + 16'd1;
        if (eff_last && !s_axis_tlast) begin
          trunc_count <= trunc_count + CNT_WIDTH'(1);
        end
      end
      if (pop && buf_p0[64]) begin
        pkt_count <= pkt_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_input_stream.sv
// Bench for input_stream: three instances (default, MAX_BEATS=4, 24-bit/MAX_BEATS=1) share
// one stimulus stream; a queue-level model predicts every output each cycle.
module tb_input_stream;

  logic        aclk = 1'b0;
  logic        resetn;
  logic        tvalid;
  logic        tlast;
  logic        full;
  logic [63:0] tdata;

  logic        tready [3];
  logic [64:0] din    [3];
  logic        wr_en  [3];
  logic [31:0] pkt    [3];
  logic [31:0] trunc  [3];
  logic [15:0] bidx   [3];

  always #5 aclk = ~aclk;

  input_stream #(.AXIS_TDATA_WIDTH(64), .MAX_BEATS(1024), .CNT_WIDTH(32)) u_def (
    .aclk(aclk), .resetn(resetn), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tready(tready[0]), .s_axis_tlast(tlast), .fifo_din(din[0]), .fifo_wr_en(wr_en[0]),
    .fifo_full(full), .pkt_count(pkt[0]), .trunc_count(trunc[0]), .beat_idx(bidx[0]));

  input_stream #(.AXIS_TDATA_WIDTH(64), .MAX_BEATS(4), .CNT_WIDTH(32)) u_trn (
    .aclk(aclk), .resetn(resetn), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tready(tready[1]), .s_axis_tlast(tlast), .fifo_din(din[1]), .fifo_wr_en(wr_en[1]),
    .fifo_full(full), .pkt_count(pkt[1]), .trunc_count(trunc[1]), .beat_idx(bidx[1]));

  input_stream #(.AXIS_TDATA_WIDTH(24), .MAX_BEATS(1), .CNT_WIDTH(32)) u_nar (
    .aclk(aclk), .resetn(resetn), .s_axis_tdata(tdata[23:0]), .s_axis_tvalid(tvalid),
    .s_axis_tready(tready[2]), .s_axis_tlast(tlast), .fifo_din(din[2]), .fifo_wr_en(wr_en[2]),
    .fifo_full(full), .pkt_count(pkt[2]), .trunc_count(trunc[2]), .beat_idx(bidx[2]));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a bounded list of pending FIFO words per instance.
  int          m_max  [3];
  logic [63:0] m_mask [3];
  bit          m_rdy_en [3];
  int          m_n    [3];
  logic [64:0] m_q    [3][2];
  int          m_bidx [3];
  logic [31:0] m_pkt  [3];
  logic [31:0] m_trunc[3];
  bit          e_rdy  [3];
  bit          e_wr   [3];
  logic [64:0] e_din  [3];

  bit          rec_en = 1'b0;
  int          rec_n  = 0;
  logic [15:0] rec_last;

  typedef struct {
    bit          v;
    bit          l;
    logic [63:0] d;
    bit          exp_rdy;
    bit          exp_wr;
    logic [64:0] exp_din;
    logic [31:0] exp_pkt;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input int idx, input logic [64:0] act, input logic [64:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h expected %h at %0t", name, idx, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_rdy_en[i] = 1'b0;
      m_n[i]      = 0;
      m_bidx[i]   = 0;
      m_pkt[i]    = '0;
      m_trunc[i]  = '0;
    end
  endtask

  task automatic predict();
    for (int i = 0; i < 3; i++) begin
      e_rdy[i] = m_rdy_en[i] && (m_n[i] < 2);
      e_wr[i]  = (m_n[i] > 0) && !full;
      e_din[i] = (m_n[i] > 0) ? m_q[i][0] : 65'd0;
    end
  endtask

  task automatic check_model();
    predict();
    for (int i = 0; i < 3; i++) begin
      chk("tready", i, 65'(tready[i]), 65'(e_rdy[i]));
      chk("wr_en", i, 65'(wr_en[i]), 65'(e_wr[i]));
      chk("din", i, din[i], e_din[i]);
      chk("pkt_count", i, 65'(pkt[i]), 65'(m_pkt[i]));
      chk("trunc_count", i, 65'(trunc[i]), 65'(m_trunc[i]));
      chk("beat_idx", i, 65'(bidx[i]), 65'(16'(m_bidx[i])));
    end
  endtask

  task automatic model_edge();
    bit acc;
    bit pop;
    bit eff;
    if (!resetn) begin
      model_reset();
    end else begin
      for (int i = 0; i < 3; i++) begin
        acc = tvalid && e_rdy[i];
        pop = e_wr[i];
        if (pop) begin
          if (m_q[i][0][64]) m_pkt[i] = m_pkt[i] + 32'd1;
          m_q[i][0] = m_q[i][1];
          m_n[i]--;
        end
        if (acc) begin
          eff = tlast || (m_bidx[i] == m_max[i] - 1);
          m_q[i][m_n[i]] = {eff, tdata & m_mask[i]};
          m_n[i]++;
          if (eff && !tlast) m_trunc[i] = m_trunc[i] + 32'd1;
          m_bidx[i] = eff ? 0 : m_bidx[i] + 1;
        end
        m_rdy_en[i] = 1'b1;
      end
    end
  endtask

  task automatic pre_cyc(input bit v, input bit l, input logic [63:0] d, input bit f);
    @(negedge aclk);
    resetn = 1'b1;
    tvalid = v;
    tlast  = l;
    tdata  = d;
    full   = f;
    #1;
    check_model();
    if (rec_en && wr_en[1] && rec_n < 16) begin
      rec_last[rec_n] = din[1][64];
      rec_n++;
    end
  endtask

  task automatic post_cyc();
    @(posedge aclk);
    model_edge();
  endtask

  task automatic cyc(input bit v, input bit l, input logic [63:0] d, input bit f);
    pre_cyc(v, l, d, f);
    post_cyc();
  endtask

  task automatic do_reset();
    @(negedge aclk);
    resetn = 1'b0;
    tvalid = 1'b0;
    tlast  = 1'b0;
    full   = 1'b0;
    model_reset();
    #1;
    check_model();
    for (int i = 0; i < 3; i++) begin
      chk("rst_wr_en", i, 65'(wr_en[i]), 65'd0);
      chk("rst_tready", i, 65'(tready[i]), 65'd0);
      chk("rst_pkt", i, 65'(pkt[i]), 65'd0);
      chk("rst_bidx", i, 65'(bidx[i]), 65'd0);
    end
    post_cyc();
    post_cyc();
  endtask

  initial begin
    int          acc_cnt;
    int          wr_cnt;
    logic [63:0] nxt;

    resetn = 1'b0;
    tvalid = 1'b0;
    tlast  = 1'b0;
    full   = 1'b0;
    tdata  = '0;
    rec_last = '0;
    m_max[0] = 1024; m_max[1] = 4; m_max[2] = 1;
    m_mask[0] = '1; m_mask[1] = '1; m_mask[2] = 64'h0000_0000_00FF_FFFF;
    model_reset();

    // Streaming vectors: row 0 is the release cycle (ready not yet enabled).
    tbl[0] = '{v: 1'b1, l: 1'b0, d: 64'd1, exp_rdy: 1'b0, exp_wr: 1'b0, exp_din: 65'd0, exp_pkt: 32'd0};
    tbl[1] = '{v: 1'b1, l: 1'b0, d: 64'd1, exp_rdy: 1'b1, exp_wr: 1'b0, exp_din: 65'd0, exp_pkt: 32'd0};
    for (int k = 2; k <= 8; k++) begin
      tbl[k] = '{v: 1'b1, l: (k == 8), d: 64'(k), exp_rdy: 1'b1, exp_wr: 1'b1,
                 exp_din: {1'b0, 64'(k - 1)}, exp_pkt: 32'd0};
    end
    tbl[9]  = '{v: 1'b0, l: 1'b0, d: 64'd0, exp_rdy: 1'b1, exp_wr: 1'b1, exp_din: {1'b1, 64'd8}, exp_pkt: 32'd0};
    tbl[10] = '{v: 1'b0, l: 1'b0, d: 64'd0, exp_rdy: 1'b1, exp_wr: 1'b0, exp_din: 65'd0, exp_pkt: 32'd1};

    do_reset();
    for (int r = 0; r < 11; r++) begin
      pre_cyc(tbl[r].v, tbl[r].l, tbl[r].d, 1'b0);
      chk("stream_tready", r, 65'(tready[0]), 65'(tbl[r].exp_rdy));
      chk("stream_wr_en", r, 65'(wr_en[0]), 65'(tbl[r].exp_wr));
      chk("stream_din", r, din[0], tbl[r].exp_din);
      chk("stream_pkt", r, 65'(pkt[0]), 65'(tbl[r].exp_pkt));
      post_cyc();
    end

    // Backpressure from an empty buffer mid-packet: two beats absorb, then ready drops.
    do_reset();
    cyc(1'b0, 1'b0, 64'd0, 1'b0);
    cyc(1'b1, 1'b0, 64'h100, 1'b0);
    cyc(1'b0, 1'b0, 64'd0, 1'b0);
    nxt = 64'h101;
    acc_cnt = 0;
    wr_cnt  = 0;
    for (int k = 0; k < 5; k++) begin
      pre_cyc(1'b1, 1'b0, nxt, 1'b1);
      if (tready[0]) begin
        acc_cnt++;
        nxt++;
      end
      if (wr_en[0]) wr_cnt++;
      post_cyc();
    end
    chk("bp_accepts", 0, 65'(acc_cnt), 65'd2);
    chk("bp_writes_while_full", 0, 65'(wr_cnt), 65'd0);
    chk("bp_tready_low", 0, 65'(tready[0]), 65'd0);
    wr_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      pre_cyc(k < 6, k == 5, nxt, 1'b0);
      if (tready[0] && k < 6) begin
        acc_cnt++;
        nxt++;
      end
      if (wr_en[0]) wr_cnt++;
      post_cyc();
    end
    chk("bp_all_written", 0, 65'(wr_cnt), 65'(acc_cnt));
    chk("bp_pkt", 0, 65'(pkt[0]), 65'd1);

    // Truncation on the MAX_BEATS=4 instance: 10-beat packet, tlast only on beat 10.
    do_reset();
    cyc(1'b0, 1'b0, 64'd0, 1'b0);
    rec_en = 1'b1;
    rec_n  = 0;
    for (int b = 1; b <= 10; b++) cyc(1'b1, b == 10, 64'(b), 1'b0);
    cyc(1'b0, 1'b0, 64'd0, 1'b0);
    cyc(1'b0, 1'b0, 64'd0, 1'b0);
    rec_en = 1'b0;
    pre_cyc(1'b0, 1'b0, 64'd0, 1'b0);
    chk("trunc_writes", 1, 65'(rec_n), 65'd10);
    chk("trunc_last_map", 1, 65'(rec_last[9:0]), 65'(10'b10_1000_1000));
    chk("trunc_pkt", 1, 65'(pkt[1]), 65'd3);
    chk("trunc_count", 1, 65'(trunc[1]), 65'd2);
    chk("trunc_bidx", 1, 65'(bidx[1]), 65'd0);
    chk("trunc_nar_count", 2, 65'(trunc[2]), 65'd9);
    post_cyc();

    // Simultaneous accept and pop with fifo_full toggling every cycle.
    do_reset();
    cyc(1'b0, 1'b0, 64'd0, 1'b0);
    cyc(1'b1, 1'b0, 64'h200, 1'b0);
    nxt = 64'h201;
    for (int k = 0; k < 24; k++) begin
      pre_cyc(1'b1, (k % 5) == 4, nxt, k[0]);
      if (tready[0]) nxt++;
      post_cyc();
    end
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 64'd0, 1'b0);

    // Narrow instance: upper input bits must not leak into fifo_din.
    do_reset();
    cyc(1'b0, 1'b0, 64'd0, 1'b0);
    cyc(1'b1, 1'b1, 64'hFFFF_FFFF_FFAB_CDEF, 1'b0);
    pre_cyc(1'b0, 1'b0, 64'd0, 1'b0);
    chk("narrow_wr_en", 2, 65'(wr_en[2]), 65'd1);
    chk("narrow_din", 2, din[2], 65'h1_0000_0000_00AB_CDEF);
    post_cyc();

    // Reset with two beats buffered and beat_idx=3, then a clean packet.
    do_reset();
    cyc(1'b0, 1'b0, 64'd0, 1'b0);
    cyc(1'b1, 1'b0, 64'hA1, 1'b0);
    cyc(1'b1, 1'b0, 64'hA2, 1'b0);
    cyc(1'b1, 1'b0, 64'hA3, 1'b1);
    pre_cyc(1'b0, 1'b0, 64'd0, 1'b1);
    chk("mid_bidx", 0, 65'(bidx[0]), 65'd3);
    chk("mid_tready", 0, 65'(tready[0]), 65'd0);
    post_cyc();
    do_reset();
    pre_cyc(1'b1, 1'b0, 64'h55, 1'b0);
    chk("post_rst_tready_release", 0, 65'(tready[0]), 65'd0);
    post_cyc();
    pre_cyc(1'b1, 1'b0, 64'h55, 1'b0);
    chk("post_rst_tready_on", 0, 65'(tready[0]), 65'd1);
    post_cyc();
    pre_cyc(1'b1, 1'b1, 64'h56, 1'b0);
    chk("post_rst_din0", 0, din[0], {1'b0, 64'h55});
    post_cyc();
    pre_cyc(1'b0, 1'b0, 64'd0, 1'b0);
    chk("post_rst_din1", 0, din[0], {1'b1, 64'h56});
    post_cyc();
    pre_cyc(1'b0, 1'b0, 64'd0, 1'b0);
    chk("post_rst_pkt", 0, 65'(pkt[0]), 65'd1);
    post_cyc();

    // Randomized traffic with occasional mid-stream resets.
    for (int k = 0; k < 900; k++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        cyc($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2,
            {$urandom, $urandom}, $urandom_range(0, 9) < 3);
      end
    end
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 64'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
